// File: rtl/led_arbiter_if.sv
// Request/pattern inputs and grant/LED outputs between status sources and the LED arbiter.
interface led_arbiter_if #(
    parameter int unsigned N_REQ = 4
);
    logic [N_REQ-1:0]   iREQ;
    logic [2*N_REQ-1:0] iMODE;
    logic [N_REQ-1:0]   oGNT;
    logic               oBUSY;
    logic               oLED;

    modport master (
        output iREQ,
        output iMODE,
        input  oGNT,
        input  oBUSY,
        input  oLED
    );

    modport slave (
        input  iREQ,
        input  iMODE,
        output oGNT,
        output oBUSY,
        output oLED
    );
endinterface

// File: rtl/led_arbiter.sv
// Fixed-priority owner of the single status LED with minimum dwell time,
// driving off / solid / slow-blink / fast-blink patterns from the owner's mode.
module led_arbiter #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned SLOW_DIV = 26999999,
    parameter int unsigned FAST_DIV = 3374999,
    parameter int unsigned MIN_HOLD = 13499999
) (
    input  logic         CLK,
    input  logic         RESETn,
    led_arbiter_if.slave bus
);
    localparam int unsigned MAX_A   = (SLOW_DIV > MIN_HOLD) ? SLOW_DIV : MIN_HOLD;
    localparam int unsigned MAX_CNT = (MAX_A > FAST_DIV) ? MAX_A : FAST_DIV;
    localparam int unsigned CNT_W   = (MAX_CNT < 1) ? 1 : $clog2(MAX_CNT + 1);
    localparam int unsigned IDX_W   = (N_REQ < 2) ? 1 : $clog2(N_REQ);

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_SOLID = 2'b01;
    localparam logic [1:0] MODE_SLOW  = 2'b10;
    localparam logic [1:0] MODE_FAST  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HOLD = 2'b01,
        OPEN = 2'b10
    } arbState_t;

    arbState_t          state, stateNext;
    logic [IDX_W-1:0]   owner, ownerNext;
    logic [N_REQ-1:0]   gnt, gntNext;
    logic [CNT_W-1:0]   holdCnt, holdNext;
    logic [CNT_W-1:0]   phaseCnt, phaseNext;
    logic [1:0]         prevMode, prevModeNext;
    logic               led, ledNext;
    logic               busy, busyNext;

    logic               grantNew_c;
    logic [IDX_W-1:0]   newOwner_c;
    logic [1:0]         ownerMode_c;
    logic [1:0]         newMode_c;
    logic               ownerReq_c;
    logic [N_REQ-1:0]   othersReq_c;
    logic [N_REQ-1:0]   higherReq_c;
    logic               holdDone_c;

    function automatic logic [IDX_W-1:0] lowestIdx(input logic [N_REQ-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    function automatic logic [1:0] modeOf(input logic [2*N_REQ-1:0] modes,
                                          input logic [IDX_W-1:0]   idx);
        logic [1:0] m;
        m = MODE_OFF;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (idx == IDX_W'(i)) m = modes[2*i +: 2];
        end
        return m;
    endfunction

    // Request views relative to the current one-hot owner; gnt-1 masks the higher-priority indices
    assign ownerReq_c  = |(bus.iREQ & gnt);
    assign othersReq_c = bus.iREQ & ~gnt;
    assign higherReq_c = bus.iREQ & (gnt - N_REQ'(1));
    assign holdDone_c  = (holdCnt == CNT_W'(MIN_HOLD));
    assign ownerMode_c = modeOf(bus.iMODE, owner);
    assign newMode_c   = modeOf(bus.iMODE, newOwner_c);

    // State register and all registered outputs
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state    <= IDLE;
            owner    <= '0;
            gnt      <= '0;
            holdCnt  <= '0;
            phaseCnt <= '0;
            prevMode <= MODE_OFF;
            led      <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= stateNext;
            owner    <= ownerNext;
            gnt      <= gntNext;
            holdCnt  <= holdNext;
            phaseCnt <= phaseNext;
            prevMode <= prevModeNext;
            led      <= ledNext;
            busy     <= busyNext;
        end
    end

    // Next state and grant decision; a release outranks both dwell and preemption
    always_comb begin
        stateNext  = state;
        grantNew_c = 1'b0;
        newOwner_c = owner;
        case (state)
            IDLE: begin
                if (|bus.iREQ) begin
                    stateNext  = HOLD;
                    grantNew_c = 1'b1;
                    newOwner_c = lowestIdx(bus.iREQ);
                end
            end
            HOLD, OPEN: begin
                if (!ownerReq_c) begin
                    if (|othersReq_c) begin
                        stateNext  = HOLD;
                        grantNew_c = 1'b1;
                        newOwner_c = lowestIdx(othersReq_c);
                    end else begin
                        stateNext = IDLE;
                    end
                end else if (holdDone_c && (|higherReq_c)) begin
                    stateNext  = HOLD;
                    grantNew_c = 1'b1;
                    newOwner_c = lowestIdx(higherReq_c);
                end else if (state == HOLD && holdDone_c) begin
                    stateNext = OPEN;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Grant, dwell counter and LED pattern for the next cycle
    always_comb begin
        ownerNext    = owner;
        gntNext      = gnt;
        holdNext     = holdCnt;
        phaseNext    = phaseCnt;
        prevModeNext = prevMode;
        ledNext      = led;

        if (stateNext == IDLE) begin
            gntNext      = '0;
            holdNext     = '0;
            phaseNext    = '0;
            prevModeNext = MODE_OFF;
            ledNext      = 1'b0;
        end else if (grantNew_c) begin
            ownerNext    = newOwner_c;
            gntNext      = N_REQ'(1) << newOwner_c;
            holdNext     = '0;
            phaseNext    = '0;
            prevModeNext = newMode_c;
            ledNext      = (newMode_c != MODE_OFF);
        end else begin
            holdNext     = holdDone_c ? holdCnt : holdCnt + CNT_W'(1);
            prevModeNext = ownerMode_c;
            if (ownerMode_c != prevMode) begin
                phaseNext = '0;
                ledNext   = (ownerMode_c != MODE_OFF);
            end else begin
                case (ownerMode_c)
                    MODE_OFF: begin
                        phaseNext = '0;
                        ledNext   = 1'b0;
                    end
                    MODE_SOLID: begin
                        phaseNext = '0;
                        ledNext   = 1'b1;
                    end
                    MODE_SLOW: begin
                        if (phaseCnt == CNT_W'(SLOW_DIV)) begin
                            phaseNext = '0;
                            ledNext   = ~led;
                        end else begin
                            phaseNext = phaseCnt + CNT_W'(1);
                        end
                    end
                    MODE_FAST: begin
                        if (phaseCnt == CNT_W'(FAST_DIV)) begin
                            phaseNext = '0;
                            ledNext   = ~led;
                        end else begin
                            phaseNext = phaseCnt + CNT_W'(1);
                        end
                    end
                endcase
            end
        end
        busyNext = |gntNext;
    end

    assign bus.oGNT  = gnt;
    assign bus.oBUSY = busy;
    assign bus.oLED  = led;

endmodule

// File: tb/tb_led_arbiter.sv
// Directed and randomized checks of led_arbiter against a cycle-level behavioural model.
module tb_led_arbiter;
    localparam int N        = 4;
    localparam int SLOW_DIV = 7;
    localparam int FAST_DIV = 1;
    localparam int MIN_HOLD = 20;

    logic         CLK;
    logic         RESETn;
    logic [3:0]   req;
    logic [7:0]   mode;

    int checks   = 0;
    int failures = 0;

    // Model: current owner (-1 = none), cycles owned, active mode, cycles since pattern start
    int mOwner   = -1;
    int mAge     = 0;
    int mMode    = 0;
    int mElapsed = 0;

    led_arbiter_if #(.N_REQ(N)) bus ();

    assign bus.iREQ  = req;
    assign bus.iMODE = mode;

    led_arbiter #(
        .N_REQ   (N),
        .SLOW_DIV(SLOW_DIV),
        .FAST_DIV(FAST_DIV),
        .MIN_HOLD(MIN_HOLD)
    ) dut (
        .CLK   (CLK),
        .RESETn(RESETn),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic int lowestSet(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic int modeFor(input logic [7:0] m, input int idx);
        logic [1:0] f;
        f = m[2*idx +: 2];
        return int'(f);
    endfunction

    function automatic logic expLed();
        if (mOwner < 0) return 1'b0;
        case (mMode)
            0: return 1'b0;
            1: return 1'b1;
            2: return ((mElapsed / (SLOW_DIV + 1)) % 2) == 0;
            default: return ((mElapsed / (FAST_DIV + 1)) % 2) == 0;
        endcase
    endfunction

    function automatic logic [3:0] expGnt();
        logic [3:0] g;
        g = 4'b0000;
        if (mOwner >= 0) g[mOwner] = 1'b1;
        return g;
    endfunction

    task automatic modelGrant(input int idx);
        mOwner   = idx;
        mAge     = 0;
        mMode    = modeFor(mode, idx);
        mElapsed = 0;
    endtask

    task automatic modelStep();
        logic [3:0] others;
        int lo;
        if (!RESETn) begin
            mOwner = -1;
        end else if (mOwner < 0) begin
            if (req != 4'b0000) modelGrant(lowestSet(req));
        end else if (!req[mOwner]) begin
            others = req;
            others[mOwner] = 1'b0;
            if (others != 4'b0000) modelGrant(lowestSet(others));
            else mOwner = -1;
        end else begin
            lo = lowestSet(req);
            if (mAge >= MIN_HOLD && lo < mOwner) begin
                modelGrant(lo);
            end else begin
                mAge++;
                if (modeFor(mode, mOwner) != mMode) begin
                    mMode    = modeFor(mode, mOwner);
                    mElapsed = 0;
                end else begin
                    mElapsed++;
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: model follows the sampled inputs, outputs compared 1 time unit after the edge
    task automatic cycle();
        @(posedge CLK);
        modelStep();
        #1;
        check("gnt", 32'(bus.oGNT), 32'(expGnt()));
        check("busy", 32'(bus.oBUSY), 32'(mOwner >= 0));
        check("led", 32'(bus.oLED), 32'(expLed()));
        check("onehot0", 32'($onehot0(bus.oGNT)), 32'(1));
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        RESETn = 1'b0;
        req    = 4'b0000;
        mode   = 8'h00;
        cycles(3);
        RESETn = 1'b1;

        // Idle for 50 cycles
        cycles(50);
        check("idle_gnt", 32'(bus.oGNT), 32'h0);
        check("idle_led", 32'(bus.oLED), 32'h0);

        // Slow blink on requester 2
        mode = 8'b0010_0000;
        req  = 4'b0100;
        cycle();
        check("slow_first_gnt", 32'(bus.oGNT), 32'h4);
        check("slow_first_led", 32'(bus.oLED), 32'h1);
        cycles(7);
        check("slow_before_toggle", 32'(bus.oLED), 32'h1);
        cycle();
        check("slow_toggle", 32'(bus.oLED), 32'h0);
        cycles(15);
        req = 4'b0000;
        cycle();
        check("release_idle", 32'(bus.oGNT), 32'h0);

        // Higher-priority request waits for the dwell time
        mode = 8'b0010_0001;
        req  = 4'b0100;
        cycle();
        cycles(5);
        req = 4'b0101;
        cycles(15);
        check("dwell_held", 32'(bus.oGNT), 32'h4);
        cycle();
        check("preempt_gnt", 32'(bus.oGNT), 32'h1);
        check("preempt_led", 32'(bus.oLED), 32'h1);

        // Owner drops early with another request pending: no idle gap
        cycles(3);
        mode = 8'b1100_0001;
        req  = 4'b1000;
        cycle();
        check("handover_gnt", 32'(bus.oGNT), 32'h8);
        check("handover_busy", 32'(bus.oBUSY), 32'h1);
        cycles(6);
        req = 4'b0000;
        cycle();
        check("last_drop_gnt", 32'(bus.oGNT), 32'h0);
        check("last_drop_led", 32'(bus.oLED), 32'h0);

        // Mode change mid-ownership restarts the phase
        mode = 8'b0000_1100;
        req  = 4'b0010;
        cycles(5);
        mode = 8'b0000_1000;
        cycles(8);
        check("restart_hold_high", 32'(bus.oLED), 32'h1);
        cycle();
        check("restart_toggle", 32'(bus.oLED), 32'h0);
        mode = 8'b0000_0100;
        cycles(10);
        check("solid_led", 32'(bus.oLED), 32'h1);
        mode = 8'b0000_0000;
        cycles(10);
        check("off_led", 32'(bus.oLED), 32'h0);

        // Reset mid-blink
        mode = 8'b0000_1100;
        cycles(3);
        RESETn = 1'b0;
        cycle();
        check("rst_gnt", 32'(bus.oGNT), 32'h0);
        check("rst_busy", 32'(bus.oBUSY), 32'h0);
        check("rst_led", 32'(bus.oLED), 32'h0);
        RESETn = 1'b1;
        req    = 4'b0000;
        cycle();

        // Simultaneous requests from idle
        mode = 8'b0101_0101;
        req  = 4'b1111;
        cycle();
        check("all_req_gnt", 32'(bus.oGNT), 32'h1);

        // Randomized traffic with slowly changing requests and modes
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(7) == 0)    req  = 4'($urandom);
            if ($urandom_range(15) == 0)   mode = 8'($urandom);
            RESETn = ($urandom_range(1999) != 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
